byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Receive-side block for the 32↔8 lane-conversion path. Runs entirely in the clk_4f domain.
- Accepts a byte stream with a per-byte valid and reassembles each group of NUM_BYTES consecutive valid bytes into one word.
- Emits each word with a one-cycle valid strobe.
- Detects words broken by a valid gap, discards the partial word, flags it, and keeps good/error word counts for the verification bench and status readout.

Parameters:
- BYTE_W, 8, width of one input lane/byte.
- NUM_BYTES, 4, bytes per output word; output width = BYTE_W*NUM_BYTES. Must be ≥2.
- MSB_FIRST, 1, 1: first received byte lands in the most significant byte of data_out. 0: first byte lands in the least significant byte.
- CNT_W, 8, width of the good/error word counters.

Ports:
- clk_4f  input  1  single block clock (byte rate).
- reset  input  1  asynchronous, active-high reset.
- data_in  input  BYTE_W  byte lane; sampled on rising clk_4f when valid_in=1.
- valid_in  input  1  byte qualifier.
- data_out  output  BYTE_W*NUM_BYTES  last completed word; registered; holds between words.
- valid_out  output  1  one-cycle strobe: data_out was updated at this edge.
- err_out  output  1  one-cycle strobe: a partial word was discarded.
- busy  output  1  1 while a word is partially collected (state COLLECT).
- words_ok  output  CNT_W  count of completed words; wraps modulo 2^CNT_W.
- words_err  output  CNT_W  count of discarded partial words; wraps.

Behaviour:
- Reset (async assert, takes effect immediately, no clock needed):
  - state=IDLE, byte index idx=0, assembly register=0.
  - data_out=0, valid_out=0, err_out=0, busy=0, words_ok=0, words_err=0.
  - On release, the first sampled edge with valid_in=1 is byte 0 of a new word.
- All outputs are registered. There is no combinational path from input to output.
- State machine, two states:
  - IDLE, valid_in=1: store byte at slot 0, idx←1, go COLLECT.
  - IDLE, valid_in=0: stay IDLE; valid_out/err_out=0.
  - COLLECT, valid_in=1, idx<NUM_BYTES-1: store byte at slot idx, idx←idx+1.
  - COLLECT, valid_in=1, idx=NUM_BYTES-1: at that same edge:
    - data_out←assembled word including this byte.
    - valid_out←1, words_ok←words_ok+1.
    - idx←0, go IDLE.
  - COLLECT, valid_in=0 (gap mid-word):
    - Discard the partial word; err_out←1, words_err←words_err+1.
    - idx←0, go IDLE. data_out keeps the last good word; valid_out=0.
- Slot mapping:
  - MSB_FIRST=1: slot k → data_out bits [(NUM_BYTES-k)*BYTE_W-1 -: BYTE_W].
  - MSB_FIRST=0: slot k → bits [k*BYTE_W +: BYTE_W].
- Latency: valid_out is high in the clk_4f cycle immediately after the cycle presenting the last byte (1-cycle latency from the last byte).
- Back-to-back words: a valid byte in the cycle after completion is byte 0 of the next word, taken from IDLE. Throughput is one word per NUM_BYTES cycles, no bubble.
- A gap of any length between words is legal and never flags an error. Only a gap after byte 0 and before the last byte is an error.
- valid_out and err_out are never high in the same cycle.
- busy is 1 exactly while state=COLLECT.
- Counters wrap (2^CNT_W-1 → 0) with no sticky flag.
- Reset asserted mid-word: the partial word is dropped silently (no err_out, no counter increment) and all outputs go to reset values.
- data_in is don't-care when valid_in=0 and must not affect state.

Test Plan:
- Reset, then bytes 2E,9F,13,05 on four consecutive valid cycles → next cycle data_out=0x2E9F1305, valid_out=1 for exactly one cycle, words_ok=1, busy=1 for cycles 2–4 only.
- Eight consecutive valid bytes 11,22,33,44,AA,BB,CC,DD → valid_out pulses twice, 4 cycles apart: 0x11223344 then 0xAABBCCDD. words_ok=2, err_out never high.
- After a good word 0x2E9F1305, send bytes 01,02, one valid_in=0 cycle, then 03,04,05,06 → err_out one pulse, words_err=1, data_out stays 0x2E9F1305 until valid_out with 0x03040506.
- Send bytes 7A,7B, then assert reset for one cycle, then C0,C1,C2,C3 → outputs zero during reset, no err_out, words_err=0, then data_out=0xC0C1C2C3, words_ok=1.
- MSB_FIRST=0 with bytes 2E,9F,13,05 → data_out=0x05139F2E.
- 256 good words with CNT_W=8 → words_ok reads 0 after the 256th valid_out, 1 after the 257th; words_err remains 0.

Source files
------------

// File: rtl/byte_word_packer.sv
// byte_word_packer: reassembles NUM_BYTES consecutive valid bytes into one
// word, strobes completed words, and drops/flags words broken by a valid gap.
// Good and broken words are tallied in wrapping counters.
module byte_word_packer #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 4,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic                        clk_4f,
  input  logic                        reset,
  input  logic [BYTE_W-1:0]           data_in,
  input  logic                        valid_in,
  output logic [BYTE_W*NUM_BYTES-1:0] data_out,
  output logic                        valid_out,
  output logic                        err_out,
  output logic                        busy,
  output logic [CNT_W-1:0]            words_ok,
  output logic [CNT_W-1:0]            words_err
);

  localparam int WORD_W = BYTE_W * NUM_BYTES;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [WORD_W-1:0]   asm_reg;
  logic [WORD_W-1:0]   data_out_reg;
  logic                valid_out_reg;
  logic                err_out_reg;
  logic                busy_reg;
  logic [CNT_W-1:0]    words_ok_reg;
  logic [CNT_W-1:0]    words_err_reg;

  // Partial word with the incoming byte dropped into the slot selected by idx.
  // In IDLE idx is 0, so this also covers storing byte 0 of a new word.
  logic [WORD_W-1:0]   merged_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
      localparam int LO = (MSB_FIRST != 0) ? (NUM_BYTES - 1 - gi) * BYTE_W : gi * BYTE_W;
      assign merged_word[LO +: BYTE_W] =
        (idx_reg == IDX_W'(gi)) ? data_in : asm_reg[LO +: BYTE_W];
    end
  endgenerate

  // Collection FSM with registered word, strobes, busy flag and counters.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      asm_reg       <= '0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      err_out_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      words_ok_reg  <= '0;
      words_err_reg <= '0;
    end else begin
      valid_out_reg <= 1'b0;
      err_out_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            asm_reg   <= merged_word;
            idx_reg   <= IDX_W'(1);
            state_reg <= COLLECT;
            busy_reg  <= 1'b1;
          end
        end
        COLLECT: begin
          if (valid_in) begin
            if (idx_reg == LAST_IDX) begin
              data_out_reg  <= merged_word;
              valid_out_reg <= 1'b1;
              words_ok_reg  <= words_ok_reg + CNT_W'(1);
              idx_reg       <= '0;
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
            end else begin
              asm_reg <= merged_word;
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end else begin
            // Gap inside a word: drop the partial word, keep the last good one.
            err_out_reg   <= 1'b1;
            words_err_reg <= words_err_reg + CNT_W'(1);
            idx_reg       <= '0;
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          idx_reg   <= '0;
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign err_out   = err_out_reg;
  assign busy      = busy_reg;
  assign words_ok  = words_ok_reg;
  assign words_err = words_err_reg;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: two instances (MSB-first and LSB-first) share one
// byte stream; a queue-based word model predicts every output after each edge.
module tb_byte_word_packer;

  localparam int N = 4;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  data_in = '0;
  logic        valid_in = 1'b0;

  logic [31:0] data_out_m, data_out_l;
  logic        valid_out_m, valid_out_l;
  logic        err_out_m, err_out_l;
  logic        busy_m, busy_l;
  logic [7:0]  words_ok_m, words_ok_l;
  logic [7:0]  words_err_m, words_err_l;

  byte_word_packer #(.BYTE_W(8), .NUM_BYTES(N), .MSB_FIRST(1), .CNT_W(8)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out_m), .valid_out(valid_out_m), .err_out(err_out_m),
    .busy(busy_m), .words_ok(words_ok_m), .words_err(words_err_m));

  byte_word_packer #(.BYTE_W(8), .NUM_BYTES(N), .MSB_FIRST(0), .CNT_W(8)) dut_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out_l), .valid_out(valid_out_l), .err_out(err_out_l),
    .busy(busy_l), .words_ok(words_ok_l), .words_err(words_err_l));

  always #5 clk_4f = ~clk_4f;

  int tests = 0;
  int fails = 0;

  // Reference model: bytes of the word in progress plus expected outputs.
  logic [7:0]  q[$];
  logic [31:0] exp_msb = '0, exp_lsb = '0;
  logic        exp_valid = 1'b0, exp_err = 1'b0;
  logic [7:0]  exp_ok = '0, exp_errcnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_msb"},  data_out_m, exp_msb);
    chk({tag, ".data_lsb"},  data_out_l, exp_lsb);
    chk({tag, ".valid"},     32'(valid_out_m), 32'(exp_valid));
    chk({tag, ".valid_lsb"}, 32'(valid_out_l), 32'(exp_valid));
    chk({tag, ".err"},       32'(err_out_m), 32'(exp_err));
    chk({tag, ".busy"},      32'(busy_m), 32'(q.size() > 0));
    chk({tag, ".ok"},        32'(words_ok_m), 32'(exp_ok));
    chk({tag, ".errcnt"},    32'(words_err_m), 32'(exp_errcnt));
    $display("[TB] %s vin=%0b din=%h out=%h/%h v=%0b e=%0b busy=%0b ok=%0d err=%0d",
             tag, valid_in, data_in, data_out_m, data_out_l, valid_out_m, err_out_m,
             busy_m, words_ok_m, words_err_m);
  endtask

  // Model: one clock edge with the given input byte.
  task automatic model_edge(input logic v, input logic [7:0] d);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (v) begin
      q.push_back(d);
      if (q.size() == N) begin
        exp_msb = '0;
        exp_lsb = '0;
        for (int i = 0; i < N; i++) begin
          exp_msb = exp_msb | (32'(q[i]) << (8 * (N - 1 - i)));
          exp_lsb = exp_lsb | (32'(q[i]) << (8 * i));
        end
        exp_valid = 1'b1;
        exp_ok    = exp_ok + 8'd1;
        q.delete();
      end
    end else if (q.size() > 0) begin
      exp_err    = 1'b1;
      exp_errcnt = exp_errcnt + 8'd1;
      q.delete();
    end
  endtask

  task automatic cycle(input string tag, input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = v ? d : 8'($urandom);
    @(posedge clk_4f);
    #1;
    model_edge(v, d);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    valid_in = 1'b0;
    reset    = 1'b1;
    #1;
    q.delete();
    exp_msb = '0; exp_lsb = '0; exp_valid = 1'b0; exp_err = 1'b0;
    exp_ok  = '0; exp_errcnt = '0;
    check_all({tag, ".async"});
    @(posedge clk_4f);
    #1;
    check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes_a[4];
    logic [7:0] bytes_b[8];
    logic [7:0] bytes_c[7];
    bytes_a = '{8'h2E, 8'h9F, 8'h13, 8'h05};
    bytes_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bytes_c = '{8'h01, 8'h02, 8'h00, 8'h03, 8'h04, 8'h05, 8'h06};

    // Power-on reset held across edges.
    reset = 1'b1;
    repeat (2) @(posedge clk_4f);
    #1;
    do_reset("por");

    // Basic word.
    for (int i = 0; i < 4; i++) cycle("word1", 1'b1, bytes_a[i]);
    chk("word1.const_msb", data_out_m, 32'h2E9F1305);
    chk("word1.const_lsb", data_out_l, 32'h05139F2E);
    chk("word1.const_ok", 32'(words_ok_m), 32'd1);
    cycle("word1.after", 1'b0, 8'h00);

    // Back-to-back words.
    for (int i = 0; i < 8; i++) begin
      cycle("b2b", 1'b1, bytes_b[i]);
      if (i == 3) chk("b2b.first", data_out_m, 32'h11223344);
    end
    chk("b2b.second", data_out_m, 32'hAABBCCDD);
    repeat (3) cycle("idle", 1'b0, 8'h00);

    // Good word, then a gap mid-word, then a good word.
    for (int i = 0; i < 4; i++) cycle("gw", 1'b1, bytes_a[i]);
    for (int i = 0; i < 7; i++) begin
      cycle("gap", i != 2, bytes_c[i]);
      if (i == 2) chk("gap.hold", data_out_m, 32'h2E9F1305);
    end
    chk("gap.new", data_out_m, 32'h03040506);
    chk("gap.errcnt", 32'(words_err_m), 32'd1);

    // Reset mid-word drops the partial silently.
    cycle("mid", 1'b1, 8'h7A);
    cycle("mid", 1'b1, 8'h7B);
    do_reset("midrst");
    for (int i = 0; i < 4; i++) cycle("post", 1'b1, 8'hC0 + 8'(i));
    chk("post.word", data_out_m, 32'hC0C1C2C3);
    chk("post.errcnt", 32'(words_err_m), 32'd0);

    // Counter wrap.
    do_reset("wrap");
    for (int w = 0; w < 256; w++)
      for (int i = 0; i < 4; i++) cycle("wrapw", 1'b1, 8'($urandom));
    chk("wrap.zero", 32'(words_ok_m), 32'd0);
    for (int i = 0; i < 4; i++) cycle("wrap257", 1'b1, 8'($urandom));
    chk("wrap.one", 32'(words_ok_m), 32'd1);
    chk("wrap.err", 32'(words_err_m), 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      else cycle("rnd", $urandom_range(0, 99) < 80, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
